sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 22, meaning client address width (bank+row+col = 2+11+9).
REQ-002 SHALL have parameter DATA_W, default 16, meaning data width.
REQ-003 SHALL have parameter WRITE_HOLD, default 4, meaning cycles the write context is held after m_ack.
REQ-004 SHALL have parameter RD_TIMEOUT, default 15, meaning maximum cycles RD_WAIT waits for m_data_r_en.
REQ-005 clk  in  1  clock; all logic on rising edge.
REQ-006 reset_l  in  1  reset, asynchronous, active-low.
REQ-007 c_req  in  3  per-client request; bit k = client k.
REQ-008 c_rh_wl  in  3  per-client direction; 1 = read, 0 = write.
REQ-009 c_addr  in  3*ADDR_W  client addresses; client k at [k*ADDR_W +: ADDR_W].
REQ-010 c_data_w  in  3*DATA_W  client write data, packed as c_addr.
REQ-011 c_ack  out  3  one-cycle acceptance pulse per client.
REQ-012 c_data_r  out  DATA_W  registered read data, shared by all clients.
REQ-013 c_data_r_en  out  3  one-cycle read-data-valid per client.
REQ-014 m_req, m_rh_wl  out  1 each  request and direction to SDRAM controller.
REQ-015 m_addr  out  ADDR_W; m_data_w  out  DATA_W; both driven from grant latches.
REQ-016 m_ack, m_data_r_en  in  1 each; m_data_r  in  DATA_W; controller responses.
REQ-017 busy  out  1  high whenever state is not IDLE.
REQ-018 owner  out  2  index of the current or last granted client.
REQ-019 rd_err  out  1  sticky read-timeout flag.

Function
REQ-020 FSM states SHALL be IDLE, GRANT, RD_WAIT and WR_HOLD.
REQ-021 IDLE with any c_req bit set -> GRANT next edge; winner is first set bit searching from (last+1) mod 3 upward with wrap; last <= winner.
REQ-022 On the IDLE->GRANT edge: owner <= winner; latch c_addr/c_rh_wl/c_data_w of winner into m_addr/m_rh_wl/m_data_w; m_req <= 1; c_ack[winner] <= 1 for exactly one cycle.
REQ-023 Latches SHALL stay stable until the next grant; client inputs are ignored outside the IDLE sampling cycle.
REQ-024 Dropping c_req after the IDLE sampling cycle SHALL NOT cancel the transaction.
REQ-025 GRANT holds m_req=1 until m_ack=1 is sampled; on that edge m_req <= 0 and state <= RD_WAIT if m_rh_wl else WR_HOLD; cycle counter cleared.
REQ-026 WR_HOLD: counter increments each cycle; on the cycle count == WRITE_HOLD-1 -> IDLE.
REQ-027 RD_WAIT: when m_data_r_en=1 -> c_data_r <= m_data_r, c_data_r_en[owner] <= 1 for one cycle, state -> IDLE.
REQ-028 RD_WAIT: counter increments each cycle; on count == RD_TIMEOUT-1 without m_data_r_en -> IDLE, rd_err <= 1, no c_data_r_en.
REQ-029 If m_data_r_en and timeout coincide, data delivery SHALL win; rd_err is unchanged.
REQ-030 m_ack outside GRANT and m_data_r_en outside RD_WAIT SHALL be ignored.
REQ-031 Arbitration is evaluated only in IDLE; minimum spacing between grants is 1 idle cycle.
REQ-032 At most one c_ack bit and at most one c_data_r_en bit SHALL be high in any cycle.

Reset
REQ-033 reset_l low SHALL asynchronously force: state IDLE; m_req, c_ack, c_data_r_en, rd_err, busy = 0; m_addr, m_data_w, c_data_r, counters = 0; m_rh_wl = 1; owner = 0; last = 2 (client 0 has first priority).
REQ-034 Reset asserted mid-transaction SHALL abandon the transaction and deliver no pending ack or data.
REQ-035 rd_err SHALL be cleared only by reset.

Verification
REQ-036 After reset, c_req=3'b111 held -> grants in order 0,1,2,0; each c_ack single-cycle pulse.
REQ-037 Client 1 read at addr 0x012345, controller model returns 0xBEEF -> m_addr=0x012345 while busy; c_data_r=0xBEEF with c_data_r_en=3'b010 one cycle after m_data_r_en.
REQ-038 Client 2 write 0xA5A5, m_ack at cycle T -> m_req low from T+1; busy low after WRITE_HOLD cycles; m_data_w=0xA5A5 stable throughout.
REQ-039 Read with m_data_r_en never returned -> IDLE after RD_TIMEOUT cycles; rd_err=1 and stays high; next request still served.
REQ-040 Client 0 drops c_req one cycle after the grant -> transaction completes normally; spurious m_ack and m_data_r_en in IDLE -> no output change.
REQ-041 reset_l pulsed low during RD_WAIT -> all outputs at reset values immediately; no c_data_r_en afterward.

Source files
------------

// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: client-side and controller-side bus of the SDRAM arbiter.
// master = arbiter side; slave = clients plus SDRAM controller side.
interface sdram_arbiter_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 16
);
    logic [2:0]          c_req;
    logic [2:0]          c_rh_wl;
    logic [3*ADDR_W-1:0] c_addr;
    logic [3*DATA_W-1:0] c_data_w;
    logic [2:0]          c_ack;
    logic [DATA_W-1:0]   c_data_r;
    logic [2:0]          c_data_r_en;

    logic                m_req;
    logic                m_rh_wl;
    logic [ADDR_W-1:0]   m_addr;
    logic [DATA_W-1:0]   m_data_w;
    logic                m_ack;
    logic                m_data_r_en;
    logic [DATA_W-1:0]   m_data_r;

    modport master (
        input  c_req, c_rh_wl, c_addr, c_data_w,
        output c_ack, c_data_r, c_data_r_en,
        output m_req, m_rh_wl, m_addr, m_data_w,
        input  m_ack, m_data_r_en, m_data_r
    );

    modport slave (
        output c_req, c_rh_wl, c_addr, c_data_w,
        input  c_ack, c_data_r, c_data_r_en,
        input  m_req, m_rh_wl, m_addr, m_data_w,
        output m_ack, m_data_r_en, m_data_r
    );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: round-robin arbiter of three clients onto one SDRAM controller.
// Ports: clk, reset_l (async, active-low), bus (master), busy, owner, rd_err.
module sdram_arbiter #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 16,
    parameter int WRITE_HOLD = 4,
    parameter int RD_TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 reset_l,
    sdram_arbiter_if.master      bus,
    output logic                 busy,
    output logic [1:0]           owner,
    output logic                 rd_err
);

    localparam int CNT_MAX = (WRITE_HOLD > RD_TIMEOUT) ? WRITE_HOLD : RD_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RD_WAIT = 2'd2,
        WR_HOLD = 2'd3
    } state_t;

    state_t           state;
    logic [1:0]       last;
    logic [1:0]       win;
    logic [1:0]       idx;
    logic [CNT_W-1:0] cnt;

    // Walk from farthest to nearest so the client right after `last` wins.
    always_comb begin
        win = last;
        idx = 2'd0;
        for (int k = 3; k >= 1; k--) begin
            idx = 2'((int'(last) + k) % 3);
            if (bus.c_req[idx]) win = idx;
        end
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state           <= IDLE;
            last            <= 2'd2;
            owner           <= 2'd0;
            cnt             <= '0;
            busy            <= 1'b0;
            rd_err          <= 1'b0;
            bus.m_req       <= 1'b0;
            bus.m_rh_wl     <= 1'b1;
            bus.m_addr      <= '0;
            bus.m_data_w    <= '0;
            bus.c_ack       <= '0;
            bus.c_data_r    <= '0;
            bus.c_data_r_en <= '0;
        end else begin
            bus.c_ack       <= '0;
            bus.c_data_r_en <= '0;
            unique case (state)
                IDLE: begin
                    if (|bus.c_req) begin
                        state        <= GRANT;
                        last         <= win;
                        owner        <= win;
                        busy         <= 1'b1;
                        bus.m_req    <= 1'b1;
                        bus.m_rh_wl  <= bus.c_rh_wl[win];
                        bus.m_addr   <= bus.c_addr[int'(win)*ADDR_W +: ADDR_W];
                        bus.m_data_w <= bus.c_data_w[int'(win)*DATA_W +: DATA_W];
                        bus.c_ack    <= 3'b001 << win;
                    end
                end
                GRANT: begin
                    if (bus.m_ack) begin
                        bus.m_req <= 1'b0;
                        cnt       <= '0;
                        state     <= bus.m_rh_wl ? RD_WAIT : WR_HOLD;
                    end
                end
                WR_HOLD: begin
                    if (cnt == CNT_W'(WRITE_HOLD - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RD_WAIT: begin
                    // Data arriving on the last allowed cycle still counts.
                    if (bus.m_data_r_en) begin
                        bus.c_data_r    <= bus.m_data_r;
                        bus.c_data_r_en <= 3'b001 << owner;
                        state           <= IDLE;
                        busy            <= 1'b0;
                    end else if (cnt == CNT_W'(RD_TIMEOUT - 1)) begin
                        rd_err <= 1'b1;
                        state  <= IDLE;
                        busy   <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: scoreboard bench for sdram_arbiter.
// Driver plays clients and controller; monitor checks every ack/data pulse.
module tb_sdram_arbiter;

    localparam int AW = 22;
    localparam int DW = 16;
    localparam int WH = 4;
    localparam int RT = 15;

    typedef struct {
        int             cl;
        logic [AW-1:0]  addr;
        logic           rw;
        logic [DW-1:0]  data;
    } grant_t;

    typedef struct {
        int             cl;
        logic [DW-1:0]  data;
    } resp_t;

    logic       clk;
    logic       reset_l;
    logic       busy;
    logic [1:0] owner;
    logic       rd_err;

    sdram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sdram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .WRITE_HOLD(WH), .RD_TIMEOUT(RT)
    ) dut (
        .clk(clk),
        .reset_l(reset_l),
        .bus(bus),
        .busy(busy),
        .owner(owner),
        .rd_err(rd_err)
    );

    int ck = 0;
    int er = 0;

    grant_t gq[$];
    resp_t  rq[$];
    int            m_last   = 2;
    logic          m_rd_err = 1'b0;
    logic [DW-1:0] m_cdr    = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ck++;
        if (act !== exp) begin
            er++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Round robin from the spec rule: first requester after the last winner.
    function automatic int rr(input logic [2:0] req, input int last);
        for (int k = 1; k <= 3; k++) begin
            if (req[(last + k) % 3]) return (last + k) % 3;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (reset_l) begin
            if (bus.c_ack != 3'b000) begin
                if (gq.size() == 0) begin
                    ck++; er++;
                    $display("FAIL ack_unexpected: got %b expected 000", bus.c_ack);
                end else begin
                    grant_t g;
                    g = gq.pop_front();
                    chk("ack_vec", 64'(bus.c_ack), 64'(3'b001 << g.cl));
                    chk("ack_owner", 64'(owner), 64'(g.cl));
                    chk("ack_addr", 64'(bus.m_addr), 64'(g.addr));
                    chk("ack_rw", 64'(bus.m_rh_wl), 64'(g.rw));
                    chk("ack_wdata", 64'(bus.m_data_w), 64'(g.data));
                    chk("ack_mreq", 64'(bus.m_req), 64'd1);
                    chk("ack_busy", 64'(busy), 64'd1);
                end
            end
            if (bus.c_data_r_en != 3'b000) begin
                if (rq.size() == 0) begin
                    ck++; er++;
                    $display("FAIL rden_unexpected: got %b expected 000",
                             bus.c_data_r_en);
                end else begin
                    resp_t r;
                    r = rq.pop_front();
                    chk("rden_vec", 64'(bus.c_data_r_en), 64'(3'b001 << r.cl));
                    chk("rdata", 64'(bus.c_data_r), 64'(r.data));
                end
            end
        end
    end

    // Entered at a negedge with the DUT idle and c_req already driven.
    task automatic txn(input bit drop, input int ack_dly, input int rd_dly,
                       input int force_cl, input logic [DW-1:0] rdata);
        grant_t g;
        int     w;
        int     n;
        w = (force_cl >= 0) ? force_cl : rr(bus.c_req, m_last);
        m_last = w;
        g.cl   = w;
        g.addr = bus.c_addr[w*AW +: AW];
        g.rw   = bus.c_rh_wl[w];
        g.data = bus.c_data_w[w*DW +: DW];
        gq.push_back(g);
        @(negedge clk);
        if (drop) begin
            bus.c_req    = 3'b000;
            bus.c_rh_wl  = 3'($urandom);
            bus.c_addr   = {AW'($urandom), AW'($urandom), AW'($urandom)};
            bus.c_data_w = {DW'($urandom), DW'($urandom), DW'($urandom)};
        end
        repeat (ack_dly) @(negedge clk);
        chk("mreq_hold", 64'(bus.m_req), 64'd1);
        bus.m_ack = 1'b1;
        @(negedge clk);
        bus.m_ack = 1'b0;
        chk("mreq_drop", 64'(bus.m_req), 64'd0);
        chk("addr_stable", 64'(bus.m_addr), 64'(g.addr));
        n = 0;
        if (!g.rw) begin
            while (busy && n < 64) begin
                chk("wdata_stable", 64'(bus.m_data_w), 64'(g.data));
                n++;
                @(negedge clk);
            end
            chk("wr_hold_len", 64'(n), 64'(WH));
        end else if (rd_dly >= 0) begin
            repeat (rd_dly) @(negedge clk);
            bus.m_data_r    = rdata;
            bus.m_data_r_en = 1'b1;
            rq.push_back('{cl: w, data: rdata});
            m_cdr = rdata;
            @(negedge clk);
            bus.m_data_r_en = 1'b0;
            chk("rd_done_idle", 64'(busy), 64'd0);
        end else begin
            while (busy && n < 64) begin
                n++;
                @(negedge clk);
            end
            chk("rd_timeout_len", 64'(n), 64'(RT));
            m_rd_err = 1'b1;
        end
        chk("rd_err", 64'(rd_err), 64'(m_rd_err));
    endtask

    task automatic spurious();
        bus.m_ack       = 1'b1;
        bus.m_data_r_en = 1'b1;
        bus.m_data_r    = DW'($urandom);
        @(negedge clk);
        bus.m_ack       = 1'b0;
        bus.m_data_r_en = 1'b0;
        @(negedge clk);
        chk("spur_busy", 64'(busy), 64'd0);
        chk("spur_mreq", 64'(bus.m_req), 64'd0);
        chk("spur_cdr", 64'(bus.c_data_r), 64'(m_cdr));
    endtask

    initial begin
        reset_l         = 1'b0;
        bus.c_req       = '0;
        bus.c_rh_wl     = '0;
        bus.c_addr      = '0;
        bus.c_data_w    = '0;
        bus.m_ack       = 1'b0;
        bus.m_data_r_en = 1'b0;
        bus.m_data_r    = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mreq", 64'(bus.m_req), 64'd0);
        chk("rst_rw", 64'(bus.m_rh_wl), 64'd1);
        chk("rst_owner", 64'(owner), 64'd0);
        chk("rst_rderr", 64'(rd_err), 64'd0);
        chk("rst_addr", 64'(bus.m_addr), 64'd0);
        chk("rst_wdata", 64'(bus.m_data_w), 64'd0);
        chk("rst_cdr", 64'(bus.c_data_r), 64'd0);
        chk("rst_ack", 64'(bus.c_ack), 64'd0);
        reset_l = 1'b1;
        @(negedge clk);

        // All three requesting continuously: grants 0,1,2,0.
        bus.c_rh_wl = 3'b000;
        for (int k = 0; k < 3; k++) begin
            bus.c_addr[k*AW +: AW]   = AW'(32'h100 + k);
            bus.c_data_w[k*DW +: DW] = DW'(32'h1000 + k);
        end
        bus.c_req = 3'b111;
        txn(0, 1, 0, 0, '0);
        txn(0, 0, 0, 1, '0);
        txn(0, 2, 0, 2, '0);
        txn(1, 1, 0, 0, '0);

        // Client 1 read returning 0xBEEF.
        bus.c_rh_wl[1]        = 1'b1;
        bus.c_addr[1*AW +: AW] = 22'h012345;
        bus.c_req             = 3'b010;
        txn(1, 2, 3, -1, 16'hBEEF);

        // Client 2 write 0xA5A5.
        bus.c_rh_wl[2]          = 1'b0;
        bus.c_data_w[2*DW +: DW] = 16'hA5A5;
        bus.c_req               = 3'b100;
        txn(1, 0, 0, -1, '0);

        // Read that never returns, then another request.
        bus.c_rh_wl[0] = 1'b1;
        bus.c_req      = 3'b001;
        txn(1, 1, -1, -1, '0);
        spurious();
        bus.c_rh_wl[1] = 1'b0;
        bus.c_req      = 3'b010;
        txn(1, 0, 0, -1, '0);

        // Reset in the middle of RD_WAIT.
        bus.c_rh_wl = 3'b001;
        bus.c_addr[0 +: AW] = 22'h3ABCDE;
        bus.c_req   = 3'b001;
        gq.push_back('{cl: rr(3'b001, m_last), addr: 22'h3ABCDE, rw: 1'b1,
                       data: bus.c_data_w[0 +: DW]});
        @(negedge clk);
        bus.c_req = 3'b000;
        bus.m_ack = 1'b1;
        @(negedge clk);
        bus.m_ack = 1'b0;
        repeat (2) @(negedge clk);
        #2 reset_l = 1'b0;
        #1;
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_mreq", 64'(bus.m_req), 64'd0);
        chk("mid_rst_rw", 64'(bus.m_rh_wl), 64'd1);
        chk("mid_rst_addr", 64'(bus.m_addr), 64'd0);
        chk("mid_rst_owner", 64'(owner), 64'd0);
        chk("mid_rst_rderr", 64'(rd_err), 64'd0);
        chk("mid_rst_cdr", 64'(bus.c_data_r), 64'd0);
        m_last   = 2;
        m_rd_err = 1'b0;
        m_cdr    = '0;
        @(negedge clk);
        reset_l = 1'b1;
        @(negedge clk);
        spurious();

        // Data on the last allowed RD_WAIT cycle wins over the timeout.
        bus.c_rh_wl = 3'b111;
        bus.c_req   = 3'b110;
        txn(1, 0, RT - 1, -1, 16'h1234);

        for (int t = 0; t < 60; t++) begin
            int rdd;
            bus.c_rh_wl = 3'($urandom);
            for (int k = 0; k < 3; k++) begin
                bus.c_addr[k*AW +: AW]   = AW'($urandom);
                bus.c_data_w[k*DW +: DW] = DW'($urandom);
            end
            bus.c_req = 3'($urandom_range(1, 7));
            rdd = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, RT - 1));
            txn(1, int'($urandom_range(0, 3)), rdd, -1, DW'($urandom));
            if ($urandom_range(0, 2) == 0) spurious();
        end

        repeat (3) @(negedge clk);
        chk("grant_q_empty", 64'(gq.size()), 64'd0);
        chk("resp_q_empty", 64'(rq.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", ck, er);
        $finish;
    end

endmodule
